// File: rtl/led_mode_controller_if.sv
// Pin-side bundle for the LED sequencer: raw button in, LED pattern, mode and step tick out.
interface led_mode_controller_if;
  logic       button;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  modport master (input button, output led, output mode, output tick);
  modport slave  (output button, input led, input mode, input tick);
endinterface

// File: rtl/led_mode_controller.sv
// Button-driven LED pattern sequencer: synchronizes and debounces the button, classifies
// short/long presses, and steps a 4-mode pattern engine (up, down, ping-pong, hold) on a divided tick.
module led_mode_controller #(
  parameter int unsigned TICK_DIV        = 10000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 200000000
) (
  input  logic                  clk_200mhz,
  input  logic                  reset,
  led_mode_controller_if.master pins
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = $clog2(LONG_CYCLES + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] LONG_VAL  = PW'(LONG_CYCLES);
  localparam logic [PW-1:0] LONG_LAST = PW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic          sync1, sync2, stable;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] press_timer;
  logic          db_accept, press_edge, release_edge;
  logic          long_press, short_press, tick, led_onehot;

  logic [TW-1:0] tick_cnt, tick_cnt_d;
  mode_t         mode_q, mode_d;
  dir_t          dir_q, dir_d;
  logic [7:0]    led_q, led_d;

  // Button is active-low; stable = 1 means released.
  assign db_accept    = (sync2 != stable) && (db_cnt == DB_LAST);
  assign press_edge   = db_accept && !sync2;
  assign release_edge = db_accept && sync2;
  assign long_press   = !stable && (press_timer == LONG_LAST);
  // A saturated timer marks a press already consumed as long, so its release is ignored.
  assign short_press  = release_edge && (press_timer != LONG_VAL);
  assign tick         = (tick_cnt == TICK_LAST);
  assign led_onehot   = (led_q != '0) && ((led_q & (led_q - 8'd1)) == '0);

  always_ff @(posedge clk_200mhz or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      stable      <= 1'b1;
      db_cnt      <= '0;
      press_timer <= '0;
    end else begin
      sync1 <= pins.button;
      sync2 <= sync1;
      if (db_accept) begin
        stable <= sync2;
        db_cnt <= '0;
      end else if (sync2 != stable) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end
      if (press_edge) begin
        press_timer <= '0;
      end else if (!stable && (press_timer != LONG_VAL)) begin
        press_timer <= press_timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_200mhz or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      mode_q   <= MODE_UP;
      dir_q    <= DIR_LEFT;
      led_q    <= '0;
    end else begin
      tick_cnt <= tick_cnt_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    dir_d      = dir_q;
    led_d      = led_q;
    tick_cnt_d = tick ? '0 : tick_cnt + 1'b1;

    // A mode change or reload wins over a coincident step and restarts the tick period.
    if (short_press || long_press) begin
      tick_cnt_d = '0;
      if (short_press) begin
        mode_d = mode_t'(mode_q + 2'd1);
      end
      unique case (mode_d)
        MODE_UP:    led_d = '0;
        MODE_DOWN:  led_d = '1;
        MODE_SHIFT: begin
          led_d = 8'h01;
          dir_d = DIR_LEFT;
        end
        MODE_HOLD:  led_d = led_q;
      endcase
    end else if (tick) begin
      unique case (mode_q)
        MODE_UP:    led_d = led_q + 8'd1;
        MODE_DOWN:  led_d = led_q - 8'd1;
        MODE_SHIFT: begin
          if (!led_onehot) begin
            led_d = 8'h01;
            dir_d = DIR_LEFT;
          end else if (dir_q == DIR_LEFT) begin
            if (led_q == 8'h80) begin
              led_d = 8'h40;
              dir_d = DIR_RIGHT;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q == 8'h01) begin
              led_d = 8'h02;
              dir_d = DIR_LEFT;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        MODE_HOLD:  led_d = led_q;
      endcase
    end
  end

  assign pins.led  = led_q;
  assign pins.mode = mode_q;
  assign pins.tick = tick;

endmodule

// File: tb/tb_led_mode_controller.sv
// Self-checking bench for led_mode_controller: hand-derived vector table, targeted corner
// sequences, and randomized button activity checked every cycle against a behavioural model.
module tb_led_mode_controller;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int LONG     = 40;

  logic clk;
  logic reset;
  led_mode_controller_if bus ();

  led_mode_controller #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk_200mhz (clk),
    .reset      (reset),
    .pins       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: button history, held-press duration, pattern as a number or LED position.
  int m_s1, m_s2, m_stable, m_run, m_held, m_mode, m_led, m_pos, m_dir, m_phase;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0; m_held = 0;
    m_mode = 0; m_led = 0; m_pos = 0; m_dir = 1; m_phase = 0;
  endfunction

  function automatic void model_load();
    case (m_mode)
      0: m_led = 0;
      1: m_led = 255;
      2: begin m_pos = 0; m_dir = 1; m_led = 1; end
      default: ;
    endcase
  endfunction

  function automatic void model_step(int b);
    int  sampled = m_s2;
    bit  changed = 0, reload = 0, advance = 0;
    int  old_held = m_held;
    int  old_stable = m_stable;
    bit  ticking = (m_phase == TICK_DIV - 1);
    m_s2 = m_s1;
    m_s1 = b;
    if (sampled != old_stable) begin
      m_run++;
      if (m_run >= DEB) begin
        changed = 1;
        m_run = 0;
        m_stable = sampled;
      end
    end else begin
      m_run = 0;
    end
    if (changed && sampled == 0) m_held = 0;
    else if (old_stable == 0 && m_held < LONG) m_held++;
    if (old_stable == 0 && !changed && old_held == LONG - 1) reload = 1;
    if (changed && sampled == 1 && old_held < LONG) advance = 1;
    if (advance || reload) begin
      if (advance) m_mode = (m_mode + 1) % 4;
      model_load();
      m_phase = 0;
    end else begin
      if (ticking) begin
        case (m_mode)
          0: m_led = (m_led + 1) % 256;
          1: m_led = (m_led + 255) % 256;
          2: begin
            if (m_pos == 7 && m_dir > 0) m_dir = -1;
            else if (m_pos == 0 && m_dir < 0) m_dir = 1;
            m_pos = m_pos + m_dir;
            m_led = 1 << m_pos;
          end
          default: ;
        endcase
      end
      m_phase = (m_phase + 1) % TICK_DIV;
    end
  endfunction

  function automatic void check_model();
    check("model_led",  bus.led,  m_led);
    check("model_mode", bus.mode, m_mode);
    check("model_tick", bus.tick, (m_phase == TICK_DIV - 1) ? 1 : 0);
  endfunction

  // Called at a negedge: drive the button, step across one rising edge, compare at next negedge.
  task automatic cycle(input logic b);
    bus.button = b;
    @(posedge clk);
    if (!reset) model_step(int'(b));
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic       level;
    int         cycles;
    int         exp_mode;
    bit         chk_led;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    logic [7:0] ping[9];

    vecs = '{
      '{1'b1, 1020, 0, 1'b1, 8'hFF},   // UP count reaches FF
      '{1'b1,    4, 0, 1'b1, 8'h00},   // wraps to 00
      '{1'b0,   10, 0, 1'b0, 8'h00},   // short press
      '{1'b1,    5, 1, 1'b1, 8'hFF},   // release accepted -> DOWN, reload FF
      '{1'b1,    3, 1, 1'b1, 8'hFF},
      '{1'b1,    1, 1, 1'b1, 8'hFE},   // first DOWN step
      '{1'b0,    2, 1, 1'b0, 8'h00},   // bounce train
      '{1'b1,    2, 1, 1'b0, 8'h00},
      '{1'b0,    2, 1, 1'b0, 8'h00},
      '{1'b1,    2, 1, 1'b0, 8'h00},
      '{1'b0,    2, 1, 1'b0, 8'h00},
      '{1'b1,    2, 1, 1'b0, 8'h00},
      '{1'b0,    2, 1, 1'b0, 8'h00},
      '{1'b1,    2, 1, 1'b0, 8'h00},
      '{1'b0,    2, 1, 1'b0, 8'h00},
      '{1'b1,   10, 1, 1'b0, 8'h00},
      '{1'b0,   10, 1, 1'b0, 8'h00},   // short press -> SHIFT
      '{1'b1,    5, 2, 1'b1, 8'h01},
      '{1'b0,   44, 2, 1'b0, 8'h00},   // long press builds up
      '{1'b0,    1, 2, 1'b1, 8'h01},   // reload at timer == LONG
      '{1'b0,   15, 2, 1'b1, 8'h08},
      '{1'b1,   10, 2, 1'b1, 8'h40}    // release after long press ignored
    };
    ping = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    reset = 1'b1;
    bus.button = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_led",  bus.led,  0);
    check("reset_mode", bus.mode, 0);
    check("reset_tick", bus.tick, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++) cycle(vecs[i].level);
      check($sformatf("vec%0d_mode", i), bus.mode, vecs[i].exp_mode);
      if (vecs[i].chk_led) check($sformatf("vec%0d_led", i), bus.led, vecs[i].exp_led);
    end

    // Ping-pong continuation: LED after each step edge.
    for (int k = 0; k < 9; k++) begin
      n = 0;
      while (!bus.tick && n < 10) begin cycle(1'b1); n++; end
      check($sformatf("ping_tick%0d", k), bus.tick, 1);
      cycle(1'b1);
      check($sformatf("ping_led%0d", k), bus.led, ping[k]);
    end

    // Short press into HOLD.
    repeat (10) cycle(1'b0);
    repeat (5) cycle(1'b1);
    check("hold_mode", bus.mode, 3);
    repeat (8) cycle(1'b1);
    check("hold_mode_kept", bus.mode, 3);

    // Async reset mid-press while tick is high; outputs must clear before any edge.
    n = 0;
    while (!bus.tick && n < 10) begin cycle(1'b1); n++; end
    check("pre_reset_tick", bus.tick, 1);
    bus.button = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_led",  bus.led,  0);
    check("async_mode", bus.mode, 0);
    check("async_tick", bus.tick, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) cycle(1'b0);
    repeat (5) cycle(1'b1);
    check("post_reset_press_mode", bus.mode, 1);
    check("post_reset_press_led",  bus.led,  8'hFF);

    // Randomized button activity, including long holds and bounce-length glitches.
    for (int s = 0; s < 60; s++) begin
      logic lvl;
      int   len;
      lvl = logic'($urandom_range(0, 1));
      len = (($urandom_range(0, 3)) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 70);
      for (int c = 0; c < len; c++) cycle(lvl);
    end
    repeat (10) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_mode_controller.md
Name: led_mode_controller

Overview:
Sequencer for the 8-LED display path. Generates the pattern step tick, debounces the user button, and runs a 4-mode pattern engine (count up, count down, ping-pong shift, hold) on the LED bus. Sits between the board button/LED pins and the clock domain of clk_200mhz. It replaces free-running LED counting with button-selected sequencing.

Parameters:
TICK_DIV, 10000000, clk_200mhz cycles per pattern step (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable synced samples required to accept a button level change (>=1)
LONG_CYCLES, 200000000, debounced-press duration that counts as a long press (> DEBOUNCE_CYCLES)

Ports:
clk_200mhz  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
button  input  1  raw board button, active-low (0 = pressed), asynchronous
led  output  8  LED pattern, bit0 = led1
mode  output  2  current mode: 0 UP, 1 DOWN, 2 SHIFT, 3 HOLD
tick  output  1  one-cycle pulse per pattern step

Behaviour:
- Reset (async assert, sync release): led=8'h00, mode=0 (UP), tick=0. Tick counter=0, debounce counter=0, stable button=released, press timer=0, shift dir=left. Synchronizer flops reset to released (1).
- Input path: 2-flop synchronizer on button. Debounce: if synced != stable, increment the debounce counter, else clear it. When the counter reaches DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
- Press timer: clears on the stable press edge and counts while stable = pressed, saturating at LONG_CYCLES.
  - Long press: on the cycle the timer reaches LONG_CYCLES, reload the pattern for the current mode. The mode is unchanged.
  - The subsequent release is ignored.
  - Short press: stable release edge with timer < LONG_CYCLES advances the mode: UP->DOWN->SHIFT->HOLD->UP.
- Mode change/reload action, registered on the same edge:
  - Tick counter cleared.
  - Pattern loaded: UP 8'h00; DOWN 8'hFF; SHIFT 8'h01 with dir=left; HOLD keeps led.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 exactly in the cycle the counter equals TICK_DIV-1.
  - The led step is applied at the end of that cycle, so led changes on the edge that ends the tick=1 cycle.
- Step rules:
  - UP: led+1 mod 256 (8'hFF -> 8'h00).
  - DOWN: led-1 mod 256 (8'h00 -> 8'hFF).
  - SHIFT: one-hot ping-pong. With dir=left: shift left; at 8'h80, set dir=right and next step gives 8'h40. With dir=right: shift right; at 8'h01, set dir=left. If led is not one-hot on entry, force 8'h01.
  - HOLD: no change. tick still pulses.
- Simultaneous events: a mode change/reload in the same cycle as tick takes priority. The step is discarded and the counter clears.
- mode output equals the internal mode register, with no extra latency.
- Reset asserted mid-press or mid-debounce returns everything to reset values. A button still held after reset is treated as a new press once debounced.

Test Plan:
1. Params TICK_DIV=4, DEBOUNCE_CYCLES=3, LONG_CYCLES=40. Release reset, button=1 -> tick every 4th cycle; led 00,01,02,03...; mode=0.
2. UP wrap: let 256 ticks elapse -> led 8'hFF then 8'h00, no glitch in tick spacing.
3. Short press: button=0 for 10 cycles, then 1 -> mode 0->1 about 2+3 cycles after release, led=8'hFF, tick counter restarts. Next tick gives 8'hFE.
4. Bounce rejection: toggle button every 2 cycles for 20 cycles, then hold 1 -> mode unchanged, no reload.
5. Long press in SHIFT (after 2 short presses): hold button=0 for 60 cycles -> at press-timer 40, led reloads 8'h01 and mode stays 2. Release causes no mode change. Stepping gives 02,04,...,80,40,20...,01,02.
6. Reset mid-operation: assert reset asynchronously in mode 3 with led=8'h5A -> led=00, mode=0, tick=0 immediately, before any clock edge.
